// File: rtl/clock_source_programmable.sv
// Multi-channel programmable clock generator.
// Each channel produces a registered square wave from one reference clock.
// High time, low time, initial level and enable are reprogrammed at run time
// through a valid/ready config port. A new setting is applied only where the
// output would go LOW->HIGH (or on the first edge when the channel is
// disabled), so no output ever shows a runt pulse.
//
// Config handshake: a transfer happens on a rising edge when cfgValid and
// cfgReady are both high. cfgReady is combinational: it is low only while the
// addressed channel already holds an unapplied config. Requests to a channel
// index >= NUM_CHANNELS see cfgReady high and are dropped.
module clock_source_programmable #(
    parameter int NUM_CHANNELS = 4,
    parameter int COUNT_WIDTH  = 16,
    parameter int DEFAULT_HIGH = 1,
    parameter int DEFAULT_LOW  = 1,
    parameter bit DEFAULT_INIT = 1'b0,
    localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                    clock,
    input  logic                    resetN,
    input  logic                    cfgValid,
    output logic                    cfgReady,
    input  logic [CH_W-1:0]         cfgChannel,
    input  logic [COUNT_WIDTH-1:0]  cfgHigh,
    input  logic [COUNT_WIDTH-1:0]  cfgLow,
    input  logic                    cfgInit,
    input  logic                    cfgEnable,
    output logic [NUM_CHANNELS-1:0] clockOut,
    output logic [NUM_CHANNELS-1:0] risePulse,
    output logic [NUM_CHANNELS-1:0] pending
);

    typedef enum logic {
        PH_LOW  = 1'b0,
        PH_HIGH = 1'b1
    } phase_t;

    localparam int SEL_N   = 2 ** CH_W;
    localparam int DEF_LEN = DEFAULT_INIT ? DEFAULT_HIGH : DEFAULT_LOW;
    localparam logic [COUNT_WIDTH-1:0] DEF_HIGH = COUNT_WIDTH'(DEFAULT_HIGH);
    localparam logic [COUNT_WIDTH-1:0] DEF_LOW  = COUNT_WIDTH'(DEFAULT_LOW);
    localparam logic [COUNT_WIDTH-1:0] DEF_CNT  =
        COUNT_WIDTH'((DEF_LEN > 1) ? DEF_LEN - 1 : 0);

    // Counter reload for a phase of length len; a zero length counts as 1.
    function automatic logic [COUNT_WIDTH-1:0] len_m1(input logic [COUNT_WIDTH-1:0] len);
        return (len == '0) ? '0 : len - COUNT_WIDTH'(1);
    endfunction

    logic [SEL_N-1:0] ready_vec;

    // Ready per addressable index; indices past the last channel always accept.
    always_comb begin
        ready_vec = '1;
        ready_vec[NUM_CHANNELS-1:0] = ~pending;
    end

    assign cfgReady = ready_vec[cfgChannel];

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        logic [COUNT_WIDTH-1:0] act_high;
        logic [COUNT_WIDTH-1:0] act_low;
        logic                   act_en;
        logic [COUNT_WIDTH-1:0] pend_high;
        logic [COUNT_WIDTH-1:0] pend_low;
        logic                   pend_init;
        logic                   pend_en;
        logic                   pend_flag;
        logic [COUNT_WIDTH-1:0] cnt;
        logic                   rise_q;
        phase_t                 phase;
        logic                   accept;
        logic                   at_rise_edge;
        logic                   apply;

        // The active init level is not stored separately: on a disabled
        // channel it is simply the held phase.
        assign accept       = cfgValid && (cfgChannel == CH_W'(i)) && !pend_flag;
        assign at_rise_edge = act_en && (cnt == '0) && (phase == PH_LOW);
        assign apply        = pend_flag && (!act_en || at_rise_edge);

        // Per-channel phase machine, counter, config registers and rise strobe.
        always_ff @(posedge clock or negedge resetN) begin
            if (!resetN) begin
                act_high  <= DEF_HIGH;
                act_low   <= DEF_LOW;
                act_en    <= 1'b1;
                pend_high <= '0;
                pend_low  <= '0;
                pend_init <= 1'b0;
                pend_en   <= 1'b0;
                pend_flag <= 1'b0;
                cnt       <= DEF_CNT;
                phase     <= DEFAULT_INIT ? PH_HIGH : PH_LOW;
                rise_q    <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                if (accept) begin
                    pend_high <= cfgHigh;
                    pend_low  <= cfgLow;
                    pend_init <= cfgInit;
                    pend_en   <= cfgEnable;
                    pend_flag <= 1'b1;
                end
                if (apply) begin
                    act_high  <= pend_high;
                    act_low   <= pend_low;
                    act_en    <= pend_en;
                    pend_flag <= 1'b0;
                    phase     <= pend_init ? PH_HIGH : PH_LOW;
                    rise_q    <= (phase == PH_LOW) && pend_init;
                    if (pend_en) begin
                        cnt <= pend_init ? len_m1(pend_high) : len_m1(pend_low);
                    end else begin
                        cnt <= '0;
                    end
                end else if (act_en) begin
                    if (cnt != '0) begin
                        cnt <= cnt - COUNT_WIDTH'(1);
                    end else if (phase == PH_LOW) begin
                        phase  <= PH_HIGH;
                        cnt    <= len_m1(act_high);
                        rise_q <= 1'b1;
                    end else begin
                        phase <= PH_LOW;
                        cnt   <= len_m1(act_low);
                    end
                end
            end
        end

        assign clockOut[i]  = (phase == PH_HIGH);
        assign risePulse[i] = rise_q;
        assign pending[i]   = pend_flag;
    end

endmodule

// File: doc/clock_source_programmable.md
# clock_source_programmable

Synthesizable, multi-channel clock-waveform generator driven by one reference clock. Each of `NUM_CHANNELS` outputs is a registered square wave whose high time, low time, initial level and enable are reprogrammed at runtime through a valid/ready config port. New settings take effect only at a low-to-high boundary, so no output ever produces a runt pulse. The block serves FPGA-hosted and simulation flows that need run-time-adjustable target clocks, where a fixed behavioural clock source is not usable.

## Interface
- `NUM_CHANNELS`, 4, number of independent clock outputs (1..32).
- `COUNT_WIDTH`, 16, width of the high- and low-time counts, in reference cycles.
- `DEFAULT_HIGH`, 1, high time per channel after reset.
- `DEFAULT_LOW`, 1, low time per channel after reset.
- `DEFAULT_INIT`, 0, level of every channel after reset.
- `clock` input 1: reference clock. Single clock domain.
- `resetN` input 1: reset, asynchronous assert, active-low.
- `cfgValid` input 1: a config request is presented.
- `cfgReady` output 1: the config request can be accepted.
- `cfgChannel` input clog2(NUM_CHANNELS) (min 1): target channel.
- `cfgHigh` input COUNT_WIDTH: high time in reference cycles.
- `cfgLow` input COUNT_WIDTH: low time in reference cycles.
- `cfgInit` input 1: starting level, and idle level while the channel is disabled.
- `cfgEnable` input 1: channel runs when 1.
- `clockOut` output NUM_CHANNELS: generated waveforms. Each bit comes straight from a flop.
- `risePulse` output NUM_CHANNELS: one-cycle strobe, high in the same cycle `clockOut[i]` first reads 1 after a 0.
- `pending` output NUM_CHANNELS: channel holds an accepted config that is not yet applied.

## Operation
- Per-channel state:
  - active config: high, low, init, enable.
  - pending config plus a pending flag.
  - down-counter `cnt`.
  - phase, HIGH or LOW. The phase drives `clockOut[i]`.
- Count clamp: a zero high or low count is treated as 1 everywhere.
- Reset state, per channel:
  - active config = defaults, enable = 1.
  - `pending` = 0.
  - phase = DEFAULT_INIT. `clockOut` = DEFAULT_INIT replicated.
  - `cnt` = (DEFAULT_INIT ? DEFAULT_HIGH : DEFAULT_LOW) − 1.
  - `risePulse` = 0.
  - Channels free-run immediately after reset.
- Running channel, each cycle:
  - If `cnt` ≠ 0, decrement it.
  - Else toggle the phase and load `cnt` = (new phase length) − 1.
  - Period = high + low. High time is exact in reference cycles.
- Config handshake:
  - `cfgReady` = !pending[cfgChannel]. This is combinational.
  - A transfer occurs on `cfgValid && cfgReady` at a rising edge.
  - The transfer latches the request into the pending register and sets `pending`.
  - If `cfgChannel` ≥ NUM_CHANNELS, `cfgReady` = 1 and the request is discarded.
- Applying a pending config on a running channel:
  - It applies in the cycle the channel would go LOW→HIGH, i.e. `cnt` = 0 in LOW phase. It never applies mid-phase.
  - Enable = 1: phase becomes the new init. `cnt` is loaded with the matching new length − 1.
  - Enable = 0: phase becomes the new init and the counter holds at 0.
  - `pending` clears in the same cycle.
- Applying a pending config on a disabled channel: it applies on the first edge after acceptance, so `pending` is high for exactly one cycle.
- Disabled channel: `clockOut[i]` holds the active init. `risePulse[i]` may fire once, when the apply raises the level from 0 to 1.
- Reset mid-operation: every channel returns asynchronously to the reset state. Pending configs are lost.

## Timing
- Config-to-effect latency:
  - Running channel: up to one full old period plus one cycle.
  - Disabled channel: 1 cycle.
- Example: HIGH=2, LOW=3, INIT=0. `clockOut` from the first post-reset edge reads 0,0,0,1,1,0,0,0,1,1,…
- `risePulse` is registered and coincides with the first 1 cycle of `clockOut`.
- Simultaneous apply and accept on one channel cannot occur, because `cfgReady` is low while pending. Accepts on different channels are independent.
- With HIGH=LOW=1 the output toggles every cycle, i.e. reference/2.

## Test plan
- Reset defaults (1/1/0), 8 cycles → `clockOut[i]` = 0,1,0,1,…; `risePulse` on every 1; `pending` = 0.
- Channel 0 set to high=2, low=3, init=0, applied → repeating 0,0,0,1,1. Channel 1 unchanged and still toggling.
- Reconfig mid-HIGH → `pending[0]` = 1 and `cfgReady` = 0 for that channel. Old high and low complete; the new waveform starts exactly at the next LOW→HIGH point. No phase shorter than min(old, new) count.
- Disable channel 2 with init=1 while running → after the boundary `clockOut[2]` = 1 constant, `risePulse[2]` fires once. Re-enable with init=0, low=4 → 0,0,0,0, then high, with `pending` set for 1 cycle only.
- Zero counts (high=0, low=0) → behaves as 1/1. `cfgChannel` = NUM_CHANNELS → `cfgReady` = 1, no state change.
- Assert `resetN` mid-period with configs pending → all outputs = DEFAULT_INIT and `pending` = 0, asynchronously, with no clock edge needed.
